beat_packer: RTL

- Upstream neighbour of the matrix-input circular buffer.
- Collects 512-bit read-response beats from the AFU host-read path. Beats may arrive out of order: halves swapped, and words completing in any order.
- Assembles each pair of halves into one 1024-bit word and writes words in strict ascending word order through the buffer's data/wrreq write port.
- Returns a per-slot credit so the read-request engine never has more than SLOTS words outstanding.

---
 rtl/beat_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/beat_packer.sv
// Reassembles out-of-order 512-bit read beats into 1024-bit words and writes them in ascending word order.
// Optional macro BEAT_PACKER_HALF_SWAP_EN places the half-0 beat in the upper half of each assembled word.
module beat_packer #(
    parameter int SLOTS = 4,
    parameter int TAG_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       word_count,
    input  logic              beat_valid,
    input  logic [TAG_W-1:0]  beat_tag,
    input  logic              beat_half,
    input  logic [511:0]      beat_data,
    input  logic              wr_finish,
    output logic [1023:0]     data,
    output logic              wrreq,
    output logic              credit,
    output logic [TAG_W-1:0]  credit_tag,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [511:0]       lo_q [SLOTS];
    logic [511:0]       hi_q [SLOTS];
    logic [SLOTS-1:0]   vLo_q, vHi_q, vLo_d, vHi_d;
    logic [TAG_W-1:0]   head_q;
    logic [15:0]        emitted_q;
    logic [15:0]        wordCount_q;
    logic [1023:0]      data_q;
    logic               wrreq_q;
    logic               credit_q;
    logic [TAG_W-1:0]   creditTag_q;
    logic               err_q;

    logic               drainEn;
    logic               lastWord;
    logic               beatHit;
    logic               beatDup;
    logic               beatWr;
    logic [1023:0]      headWord;

`ifdef BEAT_PACKER_HALF_SWAP_EN
    assign headWord = {lo_q[head_q], hi_q[head_q]};
`else
    assign headWord = {hi_q[head_q], lo_q[head_q]};
`endif

    // Valid bits are cleared by the drain first, so a beat landing in the slot being drained is kept.
    always_comb begin
        drainEn  = (state_q == RUN) && vLo_q[head_q] && vHi_q[head_q]
                   && (emitted_q < wordCount_q) && !wr_finish;
        lastWord = (emitted_q + 16'd1) == wordCount_q;
        vLo_d    = vLo_q;
        vHi_d    = vHi_q;
        if (drainEn) begin
            vLo_d[head_q] = 1'b0;
            vHi_d[head_q] = 1'b0;
        end
        beatHit = (state_q == RUN) && beat_valid;
        beatDup = beatHit && (beat_half ? vHi_d[beat_tag] : vLo_d[beat_tag]);
        beatWr  = beatHit && !beatDup;
        if (beatWr) begin
            if (beat_half) vHi_d[beat_tag] = 1'b1;
            else           vLo_d[beat_tag] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !start && beatWr) begin
            if (beat_half) hi_q[beat_tag] <= beat_data;
            else           lo_q[beat_tag] <= beat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vLo_q       <= '0;
            vHi_q       <= '0;
            head_q      <= '0;
            emitted_q   <= '0;
            wordCount_q <= '0;
            data_q      <= '0;
            wrreq_q     <= 1'b0;
            credit_q    <= 1'b0;
            creditTag_q <= '0;
            err_q       <= 1'b0;
        end else if (start) begin
            vLo_q       <= '0;
            vHi_q       <= '0;
            head_q      <= '0;
            emitted_q   <= '0;
            err_q       <= 1'b0;
            wordCount_q <= word_count;
            wrreq_q     <= 1'b0;
            credit_q    <= 1'b0;
            state_q     <= (word_count == 16'd0) ? DONE : RUN;
        end else begin
            wrreq_q  <= drainEn;
            credit_q <= drainEn;
            vLo_q    <= vLo_d;
            vHi_q    <= vHi_d;
            if (beatDup) err_q <= 1'b1;
            if (drainEn) begin
                data_q      <= headWord;
                creditTag_q <= head_q;
                head_q      <= head_q + TAG_W'(1);
                emitted_q   <= emitted_q + 16'd1;
            end
            if (state_q == RUN && (wr_finish || (drainEn && lastWord))) state_q <= DONE;
        end
    end

    assign data       = data_q;
    assign wrreq      = wrreq_q;
    assign credit     = credit_q;
    assign credit_tag = creditTag_q;
    assign err        = err_q;
    assign done       = (state_q == DONE);

endmodule
